// File: rtl/shift_arbiter.sv
// Round-robin arbiter that shares one combinational right shifter/rotator between
// two requesters and captures each result in a one-entry valid/ready output slot.
module shift_arbiter #(
  parameter int N = 16,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req,
  input  logic [N-1:0] a_in,
  input  logic [C-1:0] a_cnt,
  input  logic         a_op,
  output logic         a_gnt,
  input  logic         b_req,
  input  logic [N-1:0] b_in,
  input  logic [C-1:0] b_cnt,
  input  logic         b_op,
  output logic         b_gnt,
  output logic [N-1:0] sh_in,
  output logic [C-1:0] sh_cnt,
  output logic         sh_op,
  input  logic [N-1:0] sh_out,
  output logic         res_valid,
  output logic         res_id,
  output logic [N-1:0] res_data,
  input  logic         res_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   res_data_q, res_data_d;
  logic           res_id_q, res_id_d;
  logic           last_id_q, last_id_d;
  logic           can_accept;
  logic           grant;
  logic           grant_id;

  assign can_accept = (state_q == EMPTY) || res_ready;

  // Gnts are gated by rst so they drop the instant reset asserts.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst && can_accept) begin
      if (a_req && b_req) begin
        if (last_id_q) a_gnt = 1'b1;
        else           b_gnt = 1'b1;
      end else if (a_req) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  assign grant    = a_gnt || b_gnt;
  assign grant_id = b_gnt;

  always_comb begin
    sh_in  = '0;
    sh_cnt = '0;
    sh_op  = 1'b0;
    if (a_gnt) begin
      sh_in  = a_in;
      sh_cnt = a_cnt;
      sh_op  = a_op;
    end else if (b_gnt) begin
      sh_in  = b_in;
      sh_cnt = b_cnt;
      sh_op  = b_op;
    end
  end

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    last_id_d  = last_id_q;
    if (grant) begin
      state_d    = FULL;
      res_data_d = sh_out;
      res_id_d   = grant_id;
      last_id_d  = grant_id;
    end else if (state_q == FULL && res_ready) begin
      state_d = EMPTY;
    end
  end

  // last_id resets to B so that A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
      last_id_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      last_id_q  <= last_id_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;

endmodule
